// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: req/lock/wdata in, grant/ack/q out.
// SHARED_REG_ARBITER_WMASK_EN adds a per-bit write-enable lane alongside each wdata lane.
interface shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] wdata;
`ifdef SHARED_REG_ARBITER_WMASK_EN
    logic [NUM_REQ*DATA_W-1:0] wmask;
`endif
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         q;
    logic                      q_valid;
    logic                      busy;

`ifdef SHARED_REG_ARBITER_WMASK_EN
    modport master (output req, lock, wdata, wmask, input grant, ack, q, q_valid, busy);
    modport slave  (input req, lock, wdata, wmask, output grant, ack, q, q_valid, busy);
`else
    modport master (output req, lock, wdata, input grant, ack, q, q_valid, busy);
    modport slave  (input req, lock, wdata, output grant, ack, q, q_valid, busy);
`endif
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter writing one shared DATA_W register, with capped locked bursts.
// Define SHARED_REG_ARBITER_WMASK_EN for per-bit masked writes (q_valid needs a nonzero mask).
module shared_reg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    shared_reg_arbiter_if.slave  bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SCAN_W = PTR_W + 1;
    localparam int BCNT_W = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]          state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    owner;
    logic [BCNT_W-1:0]   bcnt;
    logic [NUM_REQ-1:0]  grant_r;
    logic [DATA_W-1:0]   q_r;
    logic                q_valid_r;

    logic [PTR_W-1:0]    winner;
    logic                found;
    logic [SCAN_W-1:0]   scan_idx;
    logic [PTR_W-1:0]    ptr_after_owner;
    logic                stay_in_burst;
    logic [DATA_W-1:0]   lane_data;
    logic [DATA_W-1:0]   q_next;
    logic                valid_set;

    // Rotating scan starting at ptr; the first requester found wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a path
        // that skips the assignment infers a latch.
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(NUM_REQ))
                scan_idx = scan_idx - SCAN_W'(NUM_REQ);
            if (!found && bus.req[scan_idx[PTR_W-1:0]]) begin
                winner = scan_idx[PTR_W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign ptr_after_owner = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign stay_in_burst   = bus.lock[owner] && bus.req[owner] &&
                             (bcnt < BCNT_W'(MAX_BURST - 1));
    assign lane_data       = bus.wdata[int'(owner) * DATA_W +: DATA_W];

`ifdef SHARED_REG_ARBITER_WMASK_EN
    logic [DATA_W-1:0] lane_mask;
    assign lane_mask = bus.wmask[int'(owner) * DATA_W +: DATA_W];
    assign q_next    = (lane_data & lane_mask) | (q_r & ~lane_mask);
    assign valid_set = |lane_mask;
`else
    assign q_next    = lane_data;
    assign valid_set = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_r <= '0;
            owner   <= '0;
            ptr     <= '0;
            bcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        owner   <= winner;
                        grant_r <= NUM_REQ'(1) << winner;
                        bcnt    <= '0;
                    end
                end
                GRANT: begin
                    if (stay_in_burst) begin
                        bcnt <= bcnt + 1'b1;
                    end else begin
                        state   <= IDLE;
                        grant_r <= '0;
                        ptr     <= ptr_after_owner;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // The register is written on every beat closing edge; a reset drops any in-flight beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else if (state == GRANT) begin
            q_r <= q_next;
            if (valid_set)
                q_valid_r <= 1'b1;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.ack     = (state == GRANT) ? grant_r : '0;
    assign bus.busy    = (state == GRANT);
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;

    a_grant_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(bus.grant));
    a_no_ack_idle   : assert property (@(posedge clock) disable iff (!reset_n)
        (state == IDLE) |-> (bus.ack == '0));
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single write, round-robin, burst cap,
// early drop, and masked writes when SHARED_REG_ARBITER_WMASK_EN is defined.
module tb_shared_reg_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    shared_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    shared_reg_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DATA_W-1:0] v);
        bus.wdata[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
`ifdef SHARED_REG_ARBITER_WMASK_EN
        bus.wmask = '1;
`endif
        #3;
        check("rst_grant",   64'(bus.grant),   64'h0);
        check("rst_ack",     64'(bus.ack),     64'h0);
        check("rst_q",       64'(bus.q),       64'h0);
        check("rst_q_valid", 64'(bus.q_valid), 64'h0);
        check("rst_busy",    64'(bus.busy),    64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single write from requester 1.
        set_lane(1, 32'h12345678);
        bus.req = 4'b0010;
        check("single_pre_grant", 64'(bus.grant), 64'h0);
        step();
        check("single_grant", 64'(bus.grant), 64'b0010);
        check("single_ack",   64'(bus.ack),   64'b0010);
        check("single_busy",  64'(bus.busy),  64'h1);
        check("single_q_lag", 64'(bus.q),     64'h0);
        bus.req = '0;
        step();
        check("single_q",       64'(bus.q),       64'h12345678);
        check("single_q_valid", 64'(bus.q_valid), 64'h1);
        check("single_idle",    64'(bus.grant),   64'h0);
        check("single_no_ack",  64'(bus.ack),     64'h0);

        // Reset asserted while granted.
        bus.req = 4'b0001;
        step();
        check("mid_grant", 64'(bus.grant), 64'b0001);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant",   64'(bus.grant),   64'h0);
        check("mid_rst_ack",     64'(bus.ack),     64'h0);
        check("mid_rst_q",       64'(bus.q),       64'h0);
        check("mid_rst_q_valid", 64'(bus.q_valid), 64'h0);
        check("mid_rst_busy",    64'(bus.busy),    64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.req = 4'b0100;
        set_lane(2, 32'hCAFE0002);
        step();
        check("post_rst_grant", 64'(bus.grant), 64'b0100);
        bus.req = '0;
        step();
        check("post_rst_q", 64'(bus.q), 64'hCAFE0002);

        // Round-robin from ptr=0 with all four requesting.
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'hA000_0000 + 32'(i));
        bus.req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            step();
            check($sformatf("rr_grant%0d", i), 64'(bus.grant), 64'(4'b0001 << i));
            check($sformatf("rr_ack%0d", i),   64'(bus.ack),   64'(4'b0001 << i));
            bus.req[i] = 1'b0;
            step();
            check($sformatf("rr_bubble%0d", i), 64'(bus.grant), 64'h0);
            check($sformatf("rr_q%0d", i),      64'(bus.q),     64'hA000_0000 + 64'(i));
        end
        check("rr_final_q", 64'(bus.q), 64'hA000_0003);

        // Burst cap: requester 0 locked, requester 1 pending.
        set_lane(1, 32'hBEEF0001);
        set_lane(0, 32'd1);
        bus.lock = 4'b0001;
        bus.req  = 4'b0011;
        step();
        check("burst_grant", 64'(bus.grant), 64'b0001);
        for (int b = 1; b <= MAX_BURST; b++) begin
            check($sformatf("burst_ack%0d", b), 64'(bus.ack), 64'b0001);
            step();
            check($sformatf("burst_q%0d", b), 64'(bus.q), 64'(b));
            if (b < MAX_BURST) begin
                check($sformatf("burst_hold%0d", b), 64'(bus.grant), 64'b0001);
                set_lane(0, 32'(b + 1));
            end
        end
        check("burst_release", 64'(bus.grant), 64'h0);
        check("burst_release_busy", 64'(bus.busy), 64'h0);
        set_lane(0, 32'd5);
        step();
        check("burst_next_owner", 64'(bus.grant), 64'b0010);
        set_lane(0, 32'd6);
        bus.req  = '0;
        bus.lock = '0;
        step();
        check("burst_next_q", 64'(bus.q), 64'hBEEF0001);

        // Early drop: requester 3 locked, req lowered during the 2nd beat.
        set_lane(3, 32'hD00D0001);
        bus.lock = 4'b1000;
        bus.req  = 4'b1000;
        step();
        check("drop_grant", 64'(bus.grant), 64'b1000);
        step();
        check("drop_q1",   64'(bus.q),     64'hD00D0001);
        check("drop_hold", 64'(bus.grant), 64'b1000);
        set_lane(3, 32'hD00D0002);
        check("drop_ack2", 64'(bus.ack), 64'b1000);
        bus.req = '0;
        step();
        check("drop_q2",   64'(bus.q),     64'hD00D0002);
        check("drop_idle", 64'(bus.grant), 64'h0);
        bus.lock = '0;
        bus.req  = 4'b0011;
        step();
        check("drop_ptr0", 64'(bus.grant), 64'b0001);
        bus.req = '0;
        step();

`ifdef SHARED_REG_ARBITER_WMASK_EN
        // Masked writes: zero mask keeps q_valid low, partial mask merges.
        pulse_reset();
        bus.wmask = '0;
        set_lane(0, 32'hFFFFFFFF);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        step();
        check("mask_zero_q",       64'(bus.q),       64'h0);
        check("mask_zero_q_valid", 64'(bus.q_valid), 64'h0);
        bus.wmask = '1;
        set_lane(0, 32'h55555555);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        step();
        check("mask_full_q", 64'(bus.q), 64'h55555555);
        bus.wmask[0 +: DATA_W] = 32'h0000FFFF;
        set_lane(0, 32'hFFFFFFFF);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        step();
        check("mask_merge_q",       64'(bus.q),       64'h5555FFFF);
        check("mask_merge_q_valid", 64'(bus.q_valid), 64'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
